// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the RV32I control path.
// Holds the opcodes the core supports, the main FSM state codes, the ALUOp
// codes handed to ALU_Decoder and the immediate-format codes.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the main FSM and the multicycle datapath.
// Ports: op/zero come from the datapath; all other signals are controls
// produced by the FSM. slave = FSM side, master = datapath side.
interface multicycle_main_fsm_if;
    logic [6:0] op;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal_instr;
    logic [3:0] state_o;

    modport slave (
        input  op, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
               illegal_instr, state_o
    );

    modport master (
        output op, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
               illegal_instr, state_o
    );
endinterface

// File: rtl/multicycle_main_fsm_imm_src_decoder.sv
// Immediate-format select decoded purely from the opcode.
// Ports: op (7) in, imm_src (2) out: 00=I, 01=S, 10=B, 11=J.
// Kept separate so a single-cycle main decoder can reuse it.
module imm_src_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end
endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core.
// Ports: clk, rst_n (async, active low), bus (slave modport) carrying
// op/zero in and all datapath controls, alu_op and state_o out.
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC + 4
//   DECODE   | read registers, compute branch/jump target in ALU
//   MEMADR   | rs1 + imm for lw/sw
//   MEMREAD  | read data memory at ALUOut
//   MEMWB    | write loaded data to rd
//   MEMWRITE | write rs2 to data memory at ALUOut
//   EXECR    | R-type ALU operation
//   EXECI    | I-type ALU operation
//   ALUWB    | write ALUOut to rd
//   JAL      | PC <= target, ALU computes return address
//   BEQ      | compare rs1/rs2, branch if zero
module multicycle_main_fsm
    import rv_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_main_fsm_if.slave  bus
);
    state_t state;
    logic   pc_update;
    logic   branch;
    logic   ir_write_d;
    logic   mem_write_d;
    logic   reg_write_d;
    logic   legal_op;

    assign legal_op = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_R) ||
                      (bus.op == OP_I)  || (bus.op == OP_JAL) || (bus.op == OP_BEQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECR;
                        OP_I:         state <= S_EXECI;
                        OP_JAL:       state <= S_JAL;
                        OP_BEQ:       state <= S_BEQ;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state <= S_MEMWB;
                S_EXECR,
                S_EXECI,
                S_JAL:      state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_update      = 1'b0;
        branch         = 1'b0;
        ir_write_d     = 1'b0;
        mem_write_d    = 1'b0;
        reg_write_d    = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ir_write_d     = 1'b1;
                pc_update      = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
            end
            S_DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            S_MEMREAD:  bus.adr_src = 1'b1;
            S_MEMWB: begin
                bus.result_src = 2'b01;
                reg_write_d    = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                mem_write_d = 1'b1;
            end
            S_EXECR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write_d = 1'b1;
            S_JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                pc_update     = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = ALUOP_SUB;
                branch        = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset forces the state to FETCH, whose decode would otherwise enable
    // PC and IR writes; gate every enable so nothing commits during reset.
    assign bus.pc_write      = rst_n & (pc_update | (branch & bus.zero));
    assign bus.ir_write      = rst_n & ir_write_d;
    assign bus.mem_write     = rst_n & mem_write_d;
    assign bus.reg_write     = rst_n & reg_write_d;
    assign bus.illegal_instr = rst_n & (state == S_DECODE) & ~legal_op;
    assign bus.state_o       = state;

    imm_src_decoder u_imm_src_decoder (
        .op      (bus.op),
        .imm_src (bus.imm_src)
    );

endmodule
